// File: rtl/rv32im_operand_stage_pkg.sv
// Shared constants for the RV32IM operand stage: operand-select encodings and widths.
// Datapath/opcode widths come from the common API_DATA_WIDTH / ALU_OPCODE_WIDTH defines.
`ifndef API_DATA_WIDTH
`define API_DATA_WIDTH 32
`endif
`ifndef ALU_OPCODE_WIDTH
`define ALU_OPCODE_WIDTH 4
`endif

package rv32im_operand_stage_pkg;
    localparam int XLEN_DEF = `API_DATA_WIDTH;
    localparam int OPW_DEF  = `ALU_OPCODE_WIDTH;
    localparam int REG_AW   = 5;

    typedef enum logic [1:0] {
        OP1_RS1      = 2'd0,
        OP1_PC       = 2'd1,
        OP1_ZERO     = 2'd2,
        OP1_ZERO_ALT = 2'd3
    } op1_sel_e;

    typedef enum logic [1:0] {
        OP2_RS2  = 2'd0,
        OP2_IMM  = 2'd1,
        OP2_FOUR = 2'd2,
        OP2_ZERO = 2'd3
    } op2_sel_e;
endpackage

// File: rtl/rv32im_fwd_mux.sv
// Hazard resolution for one source operand: EX beats MEM beats register file.
// API_OPERAND_FORWARD_EN defined: forward results (load-use stalls); undefined: any match stalls.
module rv32im_fwd_mux
    import rv32im_operand_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic              used_i,
    input  logic [REG_AW-1:0] rs_addr_i,
    input  logic [XLEN-1:0]   rf_data_i,
    input  logic              ex_valid_i,
    input  logic              ex_rd_we_i,
    input  logic [REG_AW-1:0] ex_rd_addr_i,
    input  logic              ex_is_load_i,
    input  logic [XLEN-1:0]   ex_result_i,
    input  logic              mem_valid_i,
    input  logic              mem_rd_we_i,
    input  logic [REG_AW-1:0] mem_rd_addr_i,
    input  logic [XLEN-1:0]   mem_result_i,
    output logic [XLEN-1:0]   data_o,
    output logic              stall_o
);
    logic ex_match;
    logic mem_match;

    // x0 is hardwired, so it can never be the target of a pending write
    assign ex_match  = used_i & (rs_addr_i != '0) & ex_valid_i & ex_rd_we_i
                     & (ex_rd_addr_i == rs_addr_i);
    assign mem_match = used_i & (rs_addr_i != '0) & mem_valid_i & mem_rd_we_i
                     & (mem_rd_addr_i == rs_addr_i);

`ifdef API_OPERAND_FORWARD_EN
    always_comb begin
        data_o  = rf_data_i;
        stall_o = 1'b0;
        if (ex_match) begin
            // a load's EX result is only its address; the data arrives a cycle later
            data_o  = ex_result_i;
            stall_o = ex_is_load_i;
        end else if (mem_match) begin
            data_o = mem_result_i;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{ex_is_load_i, ex_result_i, mem_result_i};
    assign data_o     = rf_data_i;
    assign stall_o    = ex_match | mem_match;
`endif
endmodule

// File: rtl/rv32im_operand_stage.sv
// ID/EX register feeding the RV32IM ALU: operand selection, RAW resolution, valid/ready.
// Forwarding versus stall-only behaviour is chosen by API_OPERAND_FORWARD_EN.
module rv32im_operand_stage
    import rv32im_operand_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int OPW  = OPW_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    output logic              id_ready_o,
    input  logic [REG_AW-1:0] id_rs1_addr_i,
    input  logic [REG_AW-1:0] id_rs2_addr_i,
    input  logic [XLEN-1:0]   id_rs1_data_i,
    input  logic [XLEN-1:0]   id_rs2_data_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic [1:0]        id_op1_sel_i,
    input  logic [1:0]        id_op2_sel_i,
    input  logic [XLEN-1:0]   id_imm_i,
    input  logic [XLEN-1:0]   id_pc_i,
    input  logic [OPW-1:0]    id_alu_opcode_i,
    input  logic [REG_AW-1:0] id_rd_addr_i,
    input  logic              id_rd_we_i,
    input  logic              id_is_load_i,
    input  logic [XLEN-1:0]   ex_result_i,
    input  logic              mem_valid_i,
    input  logic              mem_rd_we_i,
    input  logic [REG_AW-1:0] mem_rd_addr_i,
    input  logic [XLEN-1:0]   mem_result_i,
    output logic              ex_valid_o,
    input  logic              ex_ready_i,
    output logic [XLEN-1:0]   aluoperand_1_o,
    output logic [XLEN-1:0]   aluoperand_2_o,
    output logic [OPW-1:0]    alu_opcode_o,
    output logic [REG_AW-1:0] ex_rd_addr_o,
    output logic              ex_rd_we_o,
    output logic              ex_is_load_o,
    output logic [XLEN-1:0]   ex_store_data_o,
    output logic [XLEN-1:0]   ex_pc_o
);
    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    logic                         ex_valid_q, ex_valid_d;
    logic [XLEN-1:0]              op1_q, op1_d, op2_q, op2_d;
    logic [OPW-1:0]               opcode_q, opcode_d;
    logic [REG_AW-1:0]            rd_addr_q, rd_addr_d;
    logic                         rd_we_q, rd_we_d;
    logic                         is_load_q, is_load_d;
    logic [XLEN-1:0]              store_data_q, store_data_d;
    logic [XLEN-1:0]              pc_q, pc_d;

    logic [1:0]                   src_used;
    logic [1:0][REG_AW-1:0]       src_addr;
    logic [1:0][XLEN-1:0]         src_rf;
    logic [1:0][XLEN-1:0]         src_val;
    logic [1:0]                   src_stall;
    logic                         adv;
    logic                         stall;
    logic [XLEN-1:0]              op1_mux, op2_mux;

    assign src_used = {id_rs2_used_i, id_rs1_used_i};
    assign src_addr = {id_rs2_addr_i, id_rs1_addr_i};
    assign src_rf   = {id_rs2_data_i, id_rs1_data_i};

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        rv32im_fwd_mux #(.XLEN(XLEN)) u_fwd (
            .used_i       (src_used[gi]),
            .rs_addr_i    (src_addr[gi]),
            .rf_data_i    (src_rf[gi]),
            .ex_valid_i   (ex_valid_q),
            .ex_rd_we_i   (rd_we_q),
            .ex_rd_addr_i (rd_addr_q),
            .ex_is_load_i (is_load_q),
            .ex_result_i  (ex_result_i),
            .mem_valid_i  (mem_valid_i),
            .mem_rd_we_i  (mem_rd_we_i),
            .mem_rd_addr_i(mem_rd_addr_i),
            .mem_result_i (mem_result_i),
            .data_o       (src_val[gi]),
            .stall_o      (src_stall[gi])
        );
    end

    assign adv        = ~ex_valid_q | ex_ready_i;
    assign stall      = |src_stall;
    assign id_ready_o = flush_i | (adv & ~stall);

    // source selection happens after forwarding so pc/imm never see hazards
    always_comb begin
        case (op1_sel_e'(id_op1_sel_i))
            OP1_RS1: op1_mux = src_val[0];
            OP1_PC:  op1_mux = id_pc_i;
            default: op1_mux = '0;
        endcase
        case (op2_sel_e'(id_op2_sel_i))
            OP2_RS2:  op2_mux = src_val[1];
            OP2_IMM:  op2_mux = id_imm_i;
            OP2_FOUR: op2_mux = FOUR;
            default:  op2_mux = '0;
        endcase
    end

    always_comb begin
        ex_valid_d   = ex_valid_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        opcode_d     = opcode_q;
        rd_addr_d    = rd_addr_q;
        rd_we_d      = rd_we_q;
        is_load_d    = is_load_q;
        store_data_d = store_data_q;
        pc_d         = pc_q;
        if (flush_i) begin
            ex_valid_d = 1'b0;
        end else if (adv & id_valid_i & ~stall) begin
            ex_valid_d   = 1'b1;
            op1_d        = op1_mux;
            op2_d        = op2_mux;
            opcode_d     = id_alu_opcode_i;
            rd_addr_d    = id_rd_addr_i;
            rd_we_d      = id_rd_we_i;
            is_load_d    = id_is_load_i;
            store_data_d = src_val[1];
            pc_d         = id_pc_i;
        end else if (adv) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_valid_q   <= 1'b0;
            op1_q        <= '0;
            op2_q        <= '0;
            opcode_q     <= '0;
            rd_addr_q    <= '0;
            rd_we_q      <= 1'b0;
            is_load_q    <= 1'b0;
            store_data_q <= '0;
            pc_q         <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            opcode_q     <= opcode_d;
            rd_addr_q    <= rd_addr_d;
            rd_we_q      <= rd_we_d;
            is_load_q    <= is_load_d;
            store_data_q <= store_data_d;
            pc_q         <= pc_d;
        end
    end

    assign ex_valid_o      = ex_valid_q;
    assign aluoperand_1_o  = op1_q;
    assign aluoperand_2_o  = op2_q;
    assign alu_opcode_o    = opcode_q;
    assign ex_rd_addr_o    = rd_addr_q;
    assign ex_rd_we_o      = rd_we_q;
    assign ex_is_load_o    = is_load_q;
    assign ex_store_data_o = store_data_q;
    assign ex_pc_o         = pc_q;
endmodule

// File: tb/tb_rv32im_operand_stage.sv
// Self-checking bench for rv32im_operand_stage: directed pipeline scenarios plus random traffic
// against a transaction-level model; builds with or without API_OPERAND_FORWARD_EN.
module tb_rv32im_operand_stage;
    import rv32im_operand_stage_pkg::*;

    localparam int XL = XLEN_DEF;
    localparam int OW = OPW_DEF;
    localparam logic [31:0] LOAD_DATA = 32'hDEADBEEF;
`ifdef API_OPERAND_FORWARD_EN
    localparam int EXP_RAW_WAITS  = 0;
    localparam int EXP_LOAD_WAITS = 1;
`else
    localparam int EXP_RAW_WAITS  = 2;
    localparam int EXP_LOAD_WAITS = 2;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          flush_i, id_valid_i, id_ready_o;
    logic [4:0]    id_rs1_addr_i, id_rs2_addr_i;
    logic [XL-1:0] id_rs1_data_i, id_rs2_data_i;
    logic          id_rs1_used_i, id_rs2_used_i;
    logic [1:0]    id_op1_sel_i, id_op2_sel_i;
    logic [XL-1:0] id_imm_i, id_pc_i;
    logic [OW-1:0] id_alu_opcode_i;
    logic [4:0]    id_rd_addr_i;
    logic          id_rd_we_i, id_is_load_i;
    logic [XL-1:0] ex_result_i;
    logic          mem_valid_i, mem_rd_we_i;
    logic [4:0]    mem_rd_addr_i;
    logic [XL-1:0] mem_result_i;
    logic          ex_valid_o, ex_ready_i;
    logic [XL-1:0] aluoperand_1_o, aluoperand_2_o;
    logic [OW-1:0] alu_opcode_o;
    logic [4:0]    ex_rd_addr_o;
    logic          ex_rd_we_o, ex_is_load_o;
    logic [XL-1:0] ex_store_data_o, ex_pc_o;

    int n_checks = 0;
    int n_errors = 0;

    // Model of the held EX instruction, plus the MEM/WB environment around the stage
    logic          m_valid, m_we, m_ld;
    logic [31:0]   m_op1, m_op2, m_sd, m_pc;
    logic [OW-1:0] m_opc;
    logic [4:0]    m_rd;
    logic          mem_v, mem_we;
    logic [4:0]    mem_rd;
    logic [31:0]   mem_res;
    logic [31:0]   rf [32];

    always #5 clk_i = ~clk_i;

    rv32im_operand_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .id_op1_sel_i(id_op1_sel_i), .id_op2_sel_i(id_op2_sel_i),
        .id_imm_i(id_imm_i), .id_pc_i(id_pc_i), .id_alu_opcode_i(id_alu_opcode_i),
        .id_rd_addr_i(id_rd_addr_i), .id_rd_we_i(id_rd_we_i), .id_is_load_i(id_is_load_i),
        .ex_result_i(ex_result_i),
        .mem_valid_i(mem_valid_i), .mem_rd_we_i(mem_rd_we_i),
        .mem_rd_addr_i(mem_rd_addr_i), .mem_result_i(mem_result_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .aluoperand_1_o(aluoperand_1_o), .aluoperand_2_o(aluoperand_2_o),
        .alu_opcode_o(alu_opcode_o), .ex_rd_addr_o(ex_rd_addr_o),
        .ex_rd_we_o(ex_rd_we_o), .ex_is_load_o(ex_is_load_o),
        .ex_store_data_o(ex_store_data_o), .ex_pc_o(ex_pc_o)
    );

    // The ALU downstream is an adder; register file reads are write-through
    assign ex_result_i   = m_op1 + m_op2;
    assign mem_valid_i   = mem_v;
    assign mem_rd_we_i   = mem_we;
    assign mem_rd_addr_i = mem_rd;
    assign mem_result_i  = mem_res;
    assign id_rs1_data_i = rf[id_rs1_addr_i];
    assign id_rs2_data_i = rf[id_rs2_addr_i];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic writer_hit(input logic used, input logic [4:0] a,
                                        input logic v, input logic we, input logic [4:0] rd);
        return used && (a != 5'd0) && v && we && (rd == a);
    endfunction

    function automatic logic src_stall(input logic used, input logic [4:0] a);
`ifdef API_OPERAND_FORWARD_EN
        return writer_hit(used, a, m_valid, m_we, m_rd) && m_ld;
`else
        return writer_hit(used, a, m_valid, m_we, m_rd) || writer_hit(used, a, mem_v, mem_we, mem_rd);
`endif
    endfunction

    function automatic logic [31:0] src_val(input logic used, input logic [4:0] a, input logic [31:0] rfv);
`ifdef API_OPERAND_FORWARD_EN
        if (writer_hit(used, a, m_valid, m_we, m_rd)) return m_op1 + m_op2;
        if (writer_hit(used, a, mem_v, mem_we, mem_rd)) return mem_res;
`endif
        return rfv;
    endfunction

    function automatic logic exp_stall();
        return src_stall(id_rs1_used_i, id_rs1_addr_i) || src_stall(id_rs2_used_i, id_rs2_addr_i);
    endfunction

    function automatic logic [31:0] pick1(input logic [31:0] v);
        if (id_op1_sel_i == 2'd0) return v;
        if (id_op1_sel_i == 2'd1) return id_pc_i;
        return 32'd0;
    endfunction

    function automatic logic [31:0] pick2(input logic [31:0] v);
        if (id_op2_sel_i == 2'd0) return v;
        if (id_op2_sel_i == 2'd1) return id_imm_i;
        if (id_op2_sel_i == 2'd2) return 32'd4;
        return 32'd0;
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_valid <= 1'b0; m_we <= 1'b0; m_ld <= 1'b0; m_op1 <= '0; m_op2 <= '0;
            m_sd <= '0; m_pc <= '0; m_opc <= '0; m_rd <= '0;
            mem_v <= 1'b0; mem_we <= 1'b0; mem_rd <= '0; mem_res <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            mem_v   <= m_valid && ex_ready_i && !flush_i;
            mem_we  <= m_we;
            mem_rd  <= m_rd;
            mem_res <= m_ld ? LOAD_DATA : (m_op1 + m_op2);
            if (mem_v && mem_we && mem_rd != 5'd0) rf[mem_rd] <= mem_res;
            if (flush_i) begin
                m_valid <= 1'b0;
            end else if ((!m_valid || ex_ready_i) && id_valid_i && !exp_stall()) begin
                m_valid <= 1'b1;
                m_op1   <= pick1(src_val(id_rs1_used_i, id_rs1_addr_i, id_rs1_data_i));
                m_op2   <= pick2(src_val(id_rs2_used_i, id_rs2_addr_i, id_rs2_data_i));
                m_sd    <= src_val(id_rs2_used_i, id_rs2_addr_i, id_rs2_data_i);
                m_opc   <= id_alu_opcode_i;
                m_rd    <= id_rd_addr_i;
                m_we    <= id_rd_we_i;
                m_ld    <= id_is_load_i;
                m_pc    <= id_pc_i;
            end else if (!m_valid || ex_ready_i) begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk_i) begin
        if (!rst_i) begin
            chk("ex_valid", 32'(ex_valid_o), 32'(m_valid));
            chk("id_ready", 32'(id_ready_o),
                32'(flush_i || ((!m_valid || ex_ready_i) && !exp_stall())));
            if (m_valid) begin
                chk("op1", aluoperand_1_o, m_op1);
                chk("op2", aluoperand_2_o, m_op2);
                chk("opcode", 32'(alu_opcode_o), 32'(m_opc));
                chk("rd_addr", 32'(ex_rd_addr_o), 32'(m_rd));
                chk("rd_we", 32'(ex_rd_we_o), 32'(m_we));
                chk("is_load", 32'(ex_is_load_o), 32'(m_ld));
                chk("store_data", ex_store_data_o, m_sd);
                chk("pc", ex_pc_o, m_pc);
            end
        end
    end

    task automatic idle();
        id_valid_i = 1'b0; id_rs1_used_i = 1'b0; id_rs2_used_i = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [1:0] s1, input logic [1:0] s2,
                         input logic [31:0] imm, input logic ld, output int waits);
        logic acc;
        id_valid_i = 1'b1; id_rd_addr_i = rd; id_rd_we_i = 1'b1; id_is_load_i = ld;
        id_rs1_addr_i = rs1; id_rs2_addr_i = rs2; id_rs1_used_i = u1; id_rs2_used_i = u2;
        id_op1_sel_i = s1; id_op2_sel_i = s2; id_imm_i = imm; id_pc_i = 32'h1000;
        id_alu_opcode_i = '0;
        waits = 0;
        acc = 1'b0;
        while (!acc && waits <= 8) begin
            @(negedge clk_i);
            if (id_ready_o) acc = 1'b1;
            else begin
                waits++;
                @(posedge clk_i); #1;
            end
        end
        if (!acc) begin
            n_checks++; n_errors++;
            $display("FAIL accept_timeout: rd=%0d not accepted after %0d cycles", rd, waits);
        end else begin
            @(posedge clk_i); #1;
            $display("issue rd=x%0d rs1=x%0d rs2=x%0d accepted after %0d stall cycles", rd, rs1, rs2, waits);
        end
    endtask

    initial begin
        int w;
        rst_i = 1'b1; flush_i = 1'b0; ex_ready_i = 1'b1;
        id_valid_i = 1'b0; id_rs1_addr_i = '0; id_rs2_addr_i = '0; id_rs1_used_i = 1'b0;
        id_rs2_used_i = 1'b0; id_op1_sel_i = '0; id_op2_sel_i = '0; id_imm_i = '0; id_pc_i = '0;
        id_alu_opcode_i = '0; id_rd_addr_i = '0; id_rd_we_i = 1'b0; id_is_load_i = 1'b0;
        #12;
        chk("rst_ex_valid", 32'(ex_valid_o), 32'd0);
        chk("rst_opcode", 32'(alu_opcode_o), 32'd0);
        chk("rst_op1", aluoperand_1_o, 32'd0);
        chk("rst_op2", aluoperand_2_o, 32'd0);
        chk("rst_id_ready", 32'(id_ready_o), 32'd1);
        @(negedge clk_i); rst_i = 1'b0;
        @(posedge clk_i); #1;

        // addi x1,x0,5 ; add x2,x1,x1
        issue(5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 2'd0, 2'd1, 32'd5, 1'b0, w);
        issue(5'd2, 5'd1, 5'd1, 1'b1, 1'b1, 2'd0, 2'd0, 32'd0, 1'b0, w);
        chk("raw_waits", 32'(w), 32'(EXP_RAW_WAITS));
        idle();
        @(negedge clk_i);
        chk("raw_op1", aluoperand_1_o, 32'd5);
        chk("raw_op2", aluoperand_2_o, 32'd5);
        @(posedge clk_i); #1;

        // lw x3,0x100(x0) ; add x6,x3,zero
        issue(5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 2'd0, 2'd1, 32'h100, 1'b1, w);
        issue(5'd6, 5'd3, 5'd0, 1'b1, 1'b0, 2'd0, 2'd3, 32'd0, 1'b0, w);
        chk("load_use_waits", 32'(w), 32'(EXP_LOAD_WAITS));
        idle();
        @(negedge clk_i);
        chk("load_use_op1", aluoperand_1_o, LOAD_DATA);
        @(posedge clk_i); #1;

        // x4 <- 9 then x4 <- 7; consumer must see the younger value
        issue(5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 2'd0, 2'd1, 32'd9, 1'b0, w);
        issue(5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 2'd0, 2'd1, 32'd7, 1'b0, w);
        issue(5'd5, 5'd4, 5'd0, 1'b1, 1'b0, 2'd0, 2'd3, 32'd0, 1'b0, w);
        chk("prio_waits", 32'(w), 32'(EXP_RAW_WAITS));
        idle();
        @(negedge clk_i);
        chk("prio_op1", aluoperand_1_o, 32'd7);
        @(posedge clk_i); #1;

        // write to x0 must never be forwarded or cause a stall
        issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 2'd0, 2'd1, 32'd11, 1'b0, w);
        issue(5'd7, 5'd0, 5'd0, 1'b1, 1'b1, 2'd0, 2'd0, 32'd0, 1'b0, w);
        chk("x0_waits", 32'(w), 32'd0);
        idle();
        @(negedge clk_i);
        chk("x0_op1", aluoperand_1_o, 32'd0);
        chk("x0_store", ex_store_data_o, 32'd0);
        @(posedge clk_i); #1;

        // downstream back-pressure for 3 cycles
        issue(5'd8, 5'd0, 5'd0, 1'b1, 1'b0, 2'd0, 2'd1, 32'd3, 1'b0, w);
        ex_ready_i = 1'b0;
        id_valid_i = 1'b1; id_rd_addr_i = 5'd9; id_imm_i = 32'd4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("bp_id_ready", 32'(id_ready_o), 32'd0);
            chk("bp_valid", 32'(ex_valid_o), 32'd1);
            chk("bp_op2", aluoperand_2_o, 32'd3);
            @(posedge clk_i); #1;
        end
        ex_ready_i = 1'b1;
        @(negedge clk_i);
        chk("bp_release_ready", 32'(id_ready_o), 32'd1);
        @(posedge clk_i); #1;
        idle();
        @(negedge clk_i);
        chk("bp_next_op2", aluoperand_2_o, 32'd4);
        $display("backpressure: pending rd=x9 accepted on ready rise");
        @(posedge clk_i); #1;

        // flush kills both the held and the incoming instruction
        issue(5'd10, 5'd0, 5'd0, 1'b1, 1'b0, 2'd0, 2'd1, 32'd6, 1'b0, w);
        id_valid_i = 1'b1; id_rd_addr_i = 5'd11; id_imm_i = 32'd8; flush_i = 1'b1;
        @(negedge clk_i);
        chk("flush_id_ready", 32'(id_ready_o), 32'd1);
        @(posedge clk_i); #1;
        flush_i = 1'b0; idle();
        @(negedge clk_i);
        chk("flush_ex_valid", 32'(ex_valid_o), 32'd0);
        $display("flush: held rd=x10 and incoming rd=x11 dropped");
        @(posedge clk_i); #1;

        // asynchronous reset while an instruction is held
        issue(5'd12, 5'd0, 5'd0, 1'b0, 1'b0, 2'd1, 2'd1, 32'h55, 1'b0, w);
        idle();
        @(negedge clk_i);
        chk("pre_rst_valid", 32'(ex_valid_o), 32'd1);
        chk("pre_rst_op1", aluoperand_1_o, 32'h1000);
        #2 rst_i = 1'b1;
        #1;
        chk("async_rst_valid", 32'(ex_valid_o), 32'd0);
        chk("async_rst_op1", aluoperand_1_o, 32'd0);
        $display("async reset: outputs cleared before next clock");
        @(negedge clk_i); rst_i = 1'b0;
        @(posedge clk_i); #1;

        for (int c = 0; c < 3000; c++) begin
            id_valid_i      = ($urandom_range(0, 3) != 0);
            id_rs1_addr_i   = 5'($urandom_range(0, 3));
            id_rs2_addr_i   = 5'($urandom_range(0, 3));
            id_rs1_used_i   = 1'($urandom_range(0, 1));
            id_rs2_used_i   = 1'($urandom_range(0, 1));
            id_op1_sel_i    = 2'($urandom_range(0, 3));
            id_op2_sel_i    = 2'($urandom_range(0, 3));
            id_imm_i        = $urandom;
            id_pc_i         = $urandom;
            id_alu_opcode_i = OW'($urandom);
            id_rd_addr_i    = 5'($urandom_range(0, 3));
            id_rd_we_i      = 1'($urandom_range(0, 1));
            id_is_load_i    = ($urandom_range(0, 3) == 0);
            ex_ready_i      = ($urandom_range(0, 3) != 0);
            flush_i         = ($urandom_range(0, 15) == 0);
            @(posedge clk_i); #1;
        end
        idle(); flush_i = 1'b0; ex_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/rv32im_operand_stage.md
Name: rv32im_operand_stage

Overview:
ID/EX pipeline register that sits directly upstream of the RV32IM ALU and drives its operand and opcode inputs.
- Captures decoded instructions and selects operand sources (rs1/pc/zero, rs2/imm/4).
- Resolves RAW hazards against the instructions in EX and MEM by forwarding or stalling.
- Uses a valid/ready handshake with decode upstream and the EX stage downstream.

Parameters:
XLEN, `API_DATA_WIDTH (32), datapath width
OPW, `ALU_OPCODE_WIDTH, ALU opcode width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
flush_i  in  1  kill the held instruction and the incoming one
id_valid_i  in  1  decode has an instruction
id_ready_o  out  1  stage accepts the instruction this cycle
id_rs1_addr_i / id_rs2_addr_i  in  5  source register indices
id_rs1_data_i / id_rs2_data_i  in  XLEN  register-file read data (write-through from WB)
id_rs1_used_i / id_rs2_used_i  in  1  source is actually read (store counts as rs2 use)
id_op1_sel_i  in  2  0=rs1, 1=pc, 2=zero, 3=zero
id_op2_sel_i  in  2  0=rs2, 1=imm, 2=32'd4, 3=zero
id_imm_i / id_pc_i  in  XLEN  immediate, pc
id_alu_opcode_i  in  OPW  ALU opcode
id_rd_addr_i  in  5 ; id_rd_we_i  in  1 ; id_is_load_i  in  1  destination info
ex_result_i  in  XLEN  combinational ALU result of the held instruction
mem_valid_i, mem_rd_we_i  in  1 ; mem_rd_addr_i  in  5 ; mem_result_i  in  XLEN  MEM-stage writer
ex_valid_o  out  1 ; ex_ready_i  in  1  downstream handshake
aluoperand_1_o / aluoperand_2_o  out  XLEN  registered ALU operands
alu_opcode_o  out  OPW ; ex_rd_addr_o  out  5 ; ex_rd_we_o  out  1 ; ex_is_load_o  out  1
ex_store_data_o / ex_pc_o  out  XLEN  forwarded rs2 value, pc

Behaviour:
- Reset: all outputs 0, so ex_valid_o=0. alu_opcode_o=0 (ALU ADD). id_ready_o follows the combinational rule below.
- Advance: adv = ~ex_valid_o | ex_ready_i. Latency is one cycle from acceptance to ex_valid_o.
- EX match, per used source rs (rs!=0): ex_valid_o & ex_rd_we_o & ex_rd_addr_o==rs.
- MEM match, per used source rs (rs!=0): mem_valid_i & mem_rd_we_i & mem_rd_addr_i==rs.
- Priority: EX match over MEM match over register-file data.
- x0: never matches; always reads the register-file value (0).
- stall = hazard rule (see Optional Feature).
- id_ready_o = flush_i | (adv & ~stall).
- On a clock edge with flush_i: ex_valid_o<=0; the incoming instruction is dropped. Flush overrides stall and adv.
- Else if adv & id_valid_i & ~stall: load all ex_* outputs with resolved operands; ex_valid_o<=1.
- Else if adv: bubble, ex_valid_o<=0; other fields are don't-care but held.
- Else (~adv): hold everything.
- Operand mux: op1/op2 selection is applied after forwarding. ex_store_data_o always carries the forwarded rs2 value.
- While ex_valid_o & ~ex_ready_i, all outputs are stable.

Optional Feature:
Macro: API_OPERAND_FORWARD_EN.
- Defined: an EX match forwards ex_result_i, unless ex_is_load_o=1. A load-use case stalls exactly one cycle, inserting a bubble. A MEM match forwards mem_result_i.
- Undefined: any EX or MEM match stalls. The stall persists until no match remains, i.e. up to 2 bubbles. ex_result_i and mem_result_i are unused.

Decomposition:
- Package: op1/op2 select encodings and register-index width, added to the shared `DEFINITIONS.v` constants.
- Sub-module rv32im_fwd_mux: one source's match/priority/select logic, instantiated twice (rs1, rs2). Stall is the OR of their outputs.

Test Plan:
- Reset mid-transfer: assert rst_i while ex_valid_o=1 -> ex_valid_o=0 and aluoperand_1_o=0 immediately, without waiting for the clock.
- addi x1,x0,5 then add x2,x1,x1 (fwd on) -> second instruction issues back-to-back with operands 5/5; with the macro off -> exactly 2 bubbles, then operands 5/5 from the register file.
- Load to x3, then use of x3 (fwd on) -> one bubble (ex_valid_o=0 for 1 cycle); the next issue takes mem_result_i=0xDEADBEEF.
- ex_ready_i=0 for 3 cycles with ex_valid_o=1 -> outputs stable, id_ready_o=0; the pending instruction is accepted on the cycle ex_ready_i rises.
- flush_i with id_valid_i=1 and ex_valid_o=1 -> next cycle ex_valid_o=0, id_ready_o=1 during the flush cycle.
- EX and MEM both write x4 (values 7 and 9); consumer reads x4 -> operand=7 (EX priority). Writes to x0 are never forwarded.
